// File: rtl/request_unit.sv
// Request unit: sequences instruction fetch and optional data access, drives memory
// request lines, PC enable and a sticky halt. Optional counters behind REQ_PERF_EN.
module request_unit
`ifdef REQ_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic CLK,
  input  logic nRST,
  input  logic cu_iREN,
  input  logic cu_dREN,
  input  logic cu_dWEN,
  input  logic cu_halt,
  input  logic ihit,
  input  logic dhit,
  output logic imemREN,
  output logic dmemREN,
  output logic dmemWEN,
  output logic pc_en,
  output logic halt
`ifdef REQ_PERF_EN
  ,
  output logic [PERF_W-1:0] instr_cnt,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MEM    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   dreq_q, dreq_d;
  logic   dwen_q, dwen_d;
  logic   halt_q, halt_d;
  logic   pc_en_d;
  logic   halt_entry;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      dreq_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dreq_q  <= dreq_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dreq_d     = dreq_q;
    dwen_d     = dwen_q;
    halt_d     = halt_q;
    pc_en_d    = 1'b0;
    halt_entry = 1'b0;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          // Halt takes precedence over any data access decoded alongside it.
          if (cu_halt) begin
            state_d    = HALTED;
            halt_d     = 1'b1;
            halt_entry = 1'b1;
          end else if (cu_dREN || cu_dWEN) begin
            state_d = MEM;
            dwen_d  = cu_dWEN;
            dreq_d  = cu_dREN & ~cu_dWEN;
          end else begin
            pc_en_d = 1'b1;
          end
        end
      end
      MEM: begin
        if (dhit) begin
          pc_en_d = 1'b1;
          dreq_d  = 1'b0;
          dwen_d  = 1'b0;
          state_d = FETCH;
        end
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase
  end

  assign imemREN = cu_iREN & (state_q != HALTED);
  assign dmemREN = dreq_q & (state_q == MEM);
  assign dmemWEN = dwen_q & (state_q == MEM);
  assign pc_en   = pc_en_d & nRST;
  assign halt    = halt_q;

`ifdef REQ_PERF_EN
  logic [PERF_W-1:0] instr_cnt_q, stall_cnt_q;
  logic              instr_inc, stall_inc;

  assign instr_inc = pc_en_d | halt_entry;
  assign stall_inc = ((state_q == FETCH) & ~ihit) | ((state_q == MEM) & ~dhit);

  // Counters saturate; HALTED never raises either increment, so they freeze there.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (instr_inc && (instr_cnt_q != '1)) instr_cnt_q <= instr_cnt_q + 1'b1;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_halt_entry;
  assign unused_halt_entry = halt_entry;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit; counter section is active when REQ_PERF_EN is defined.
module tb_request_unit;
  logic CLK = 1'b0;
  logic nRST;
  logic cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit;
  logic imemREN, dmemREN, dmemWEN, pc_en, halt;
`ifdef REQ_PERF_EN
  logic [3:0] instr_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

`ifdef REQ_PERF_EN
  request_unit #(.PERF_W(4)) dut (
`else
  request_unit dut (
`endif
    .CLK(CLK), .nRST(nRST),
    .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .ihit(ihit), .dhit(dhit),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt)
`ifdef REQ_PERF_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    cu_dREN = 0; cu_dWEN = 0; cu_halt = 0; ihit = 0; dhit = 0;
  endtask

  initial begin
    nRST = 0; cu_iREN = 1; clr();
    ihit = 1;
    #12;
    chk("rst_imemREN", imemREN, 1);
    chk("rst_dmemREN", dmemREN, 0);
    chk("rst_dmemWEN", dmemWEN, 0);
    chk("rst_halt", halt, 0);
    chk("rst_pc_en_gated", pc_en, 0);
    tick();
    nRST = 1; ihit = 0;
    tick();

    // ALU instruction retires in the fetch cycle
    ihit = 1; #1;
    chk("alu_pc_en", pc_en, 1);
    chk("alu_dmemREN", dmemREN, 0);
    tick();
    chk("alu_stay_fetch_pc_en", pc_en, 1);
    chk("alu_dmemWEN", dmemWEN, 0);
    ihit = 0; #1;
    chk("fetch_wait_pc_en", pc_en, 0);

    // load with three wait cycles
    ihit = 1; cu_dREN = 1; #1;
    chk("ld_fetch_pc_en", pc_en, 0);
    tick();
    clr(); #1;
    chk("ld_dmemREN", dmemREN, 1);
    chk("ld_dmemWEN", dmemWEN, 0);
    for (int i = 0; i < 3; i++) begin
      ihit = 1; dhit = 0; #1;
      chk("ld_wait_pc_en", pc_en, 0);
      chk("ld_wait_dmemREN", dmemREN, 1);
      tick();
    end
    ihit = 0; dhit = 1; #1;
    chk("ld_dhit_pc_en", pc_en, 1);
    tick();
    clr(); #1;
    chk("ld_done_dmemREN", dmemREN, 0);
    chk("ld_done_pc_en", pc_en, 0);

    // read and write both decoded: write wins
    ihit = 1; cu_dREN = 1; cu_dWEN = 1;
    tick();
    clr(); #1;
    chk("conf_dmemWEN", dmemWEN, 1);
    chk("conf_dmemREN", dmemREN, 0);
    dhit = 1; #1;
    chk("st_dhit_pc_en", pc_en, 1);
    tick();
    clr(); #1;
    chk("st_done_dmemWEN", dmemWEN, 0);

    // halt beats data access decode
    ihit = 1; cu_halt = 1; cu_dREN = 1; #1;
    chk("halt_fetch_pc_en", pc_en, 0);
    chk("halt_not_yet", halt, 0);
    tick();
    clr(); #1;
    chk("halt_set", halt, 1);
    chk("halt_imemREN", imemREN, 0);
    chk("halt_dmemREN", dmemREN, 0);
    chk("halt_pc_en", pc_en, 0);
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0]; cu_dREN = i[1]; cu_dWEN = ~i[1]; #1;
      chk("halted_halt", halt, 1);
      chk("halted_pc_en", pc_en, 0);
      chk("halted_reqs", {imemREN, dmemREN, dmemWEN}, 0);
      tick();
    end
    clr();
    nRST = 0; #1;
    chk("halt_cleared_by_rst", halt, 0);
    chk("halt_rst_imemREN", imemREN, 1);
    tick();
    nRST = 1;
    tick();

    // reset in the middle of a pending load
    ihit = 1; cu_dREN = 1;
    tick();
    clr(); #1;
    chk("midmem_dmemREN", dmemREN, 1);
    #2; nRST = 0; #1;
    chk("midmem_rst_dmemREN", dmemREN, 0);
    chk("midmem_rst_dmemWEN", dmemWEN, 0);
    chk("midmem_rst_halt", halt, 0);
    chk("midmem_rst_imemREN", imemREN, 1);
    tick();
    nRST = 1;
    tick();
    ihit = 1; #1;
    chk("after_rst_fetch_pc_en", pc_en, 1);
    tick();
    clr();

`ifdef REQ_PERF_EN
    nRST = 0; #1;
    chk("perf_rst_instr", instr_cnt, 0);
    chk("perf_rst_stall", stall_cnt, 0);
    tick();
    nRST = 1;
    for (int k = 0; k < 20; k++) begin
      ihit = 0;
      tick();
      ihit = 1;
      tick();
      if (k == 4) begin
        chk("perf_instr_5", instr_cnt, 5);
        chk("perf_stall_5", stall_cnt, 5);
      end
    end
    clr();
    chk("perf_instr_sat", instr_cnt, 15);
    ihit = 1; cu_halt = 1;
    tick();
    clr(); #1;
    ihit = 0;
    tick(); tick();
    chk("perf_stall_sat_frozen", stall_cnt, 15);
    chk("perf_instr_frozen", instr_cnt, 15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
